// File: rtl/cla_rr_arbiter.sv
// rtl/cla_rr_arbiter.sv - round-robin scheduler sharing one registered adder among NUM_REQ requesters
// Grants one request per cycle, tags it through the adder latency and returns the sum to its owner.
module cla_rr_arbiter #(
  parameter int  NUM_REQ = 4,
  parameter int  WIDTH   = 32,
  parameter int  LAT     = 1,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH:0]           add_sum,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH:0]           rsp_sum,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);

  logic [IDW-1:0]     r_ptr;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;
  logic [LAT:0]       r_tag_v;
  logic [IDW-1:0]     r_tag_id [0:LAT];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH:0]     r_rsp_sum;
  logic [IDW-1:0]     r_rsp_id;

  logic               w_gnt_any;
  logic [IDW-1:0]     w_gnt_idx;
  logic [IDW-1:0]     w_ptr_nxt;
  logic               w_fire;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  int                 w_scan;

  // Scan downward from the farthest offset so the slot nearest the pointer wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_scan    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan = (int'(r_ptr) + k) % NUM_REQ;
      if (req_valid[IDW'(w_scan)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDW'(w_scan);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && w_gnt_any) begin
      req_ready = NUM_REQ'(1) << w_gnt_idx;
    end
  end

  assign w_fire    = |(req_valid & req_ready);
  assign w_ptr_nxt = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_sel_a   = req_a[int'(w_gnt_idx) * WIDTH +: WIDTH];
  assign w_sel_b   = req_b[int'(w_gnt_idx) * WIDTH +: WIDTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_add_a <= '0;
      r_add_b <= '0;
    end else if (w_fire) begin
      r_ptr   <= w_ptr_nxt;
      r_add_a <= w_sel_a;
      r_add_b <= w_sel_b;
    end
  end

  // Stage 0 is loaded at issue; stage LAT lines up with add_sum for the response edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag_v <= '0;
      for (int k = 0; k <= LAT; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_v[0] <= w_fire;
      if (w_fire) begin
        r_tag_id[0] <= w_gnt_idx;
      end
      for (int k = 1; k <= LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= '0;
      r_rsp_sum   <= '0;
      r_rsp_id    <= '0;
    end else if (r_tag_v[LAT]) begin
      r_rsp_valid <= NUM_REQ'(1) << r_tag_id[LAT];
      r_rsp_sum   <= add_sum;
      r_rsp_id    <= r_tag_id[LAT];
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_rsp_id;
  assign busy      = (|r_tag_v) | (|r_rsp_valid);

endmodule

// File: tb/tb_cla_rr_arbiter.sv
// tb/tb_cla_rr_arbiter.sv - scoreboard bench for cla_rr_arbiter with adder latency 1 and 3
// Both instances see identical requests; each has its own adder model and expected-response queue.
module tb_cla_rr_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  typedef struct {
    int         id;
    logic [W:0] sum;
    int         due;
  } exp_t;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]   pend = '0;
  logic [W-1:0]   pa [N];
  logic [W-1:0]   pb [N];
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;

  always_comb begin
    req_valid = pend;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = pa[i];
      req_b[i*W +: W] = pb[i];
    end
  end

  logic [N-1:0]   ready1, ready3, rsp_valid1, rsp_valid3;
  logic [W-1:0]   add_a1, add_b1, add_a3, add_b3;
  logic [W:0]     add_sum1, add_sum3, rsp_sum1, rsp_sum3;
  logic [IDW-1:0] rsp_id1, rsp_id3;
  logic           busy1, busy3;

  cla_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .LAT(1)) u_dut_l1 (
    .clock(clock), .reset(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(ready1), .add_a(add_a1), .add_b(add_b1), .add_sum(add_sum1),
    .rsp_valid(rsp_valid1), .rsp_sum(rsp_sum1), .rsp_id(rsp_id1), .busy(busy1)
  );

  cla_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .LAT(3)) u_dut_l3 (
    .clock(clock), .reset(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(ready3), .add_a(add_a3), .add_b(add_b3), .add_sum(add_sum3),
    .rsp_valid(rsp_valid3), .rsp_sum(rsp_sum3), .rsp_id(rsp_id3), .busy(busy3)
  );

  logic [W:0] s1 = '0;
  logic [W:0] s3 [3] = '{default: '0};
  always @(posedge clock) begin
    s1    <= {1'b0, add_a1} + {1'b0, add_b1};
    s3[0] <= {1'b0, add_a3} + {1'b0, add_b3};
    s3[1] <= s3[0];
    s3[2] <= s3[1];
  end
  assign add_sum1 = s1;
  assign add_sum3 = s3[2];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   n_pass = 0, n_total = 0;
  exp_t q1 [$];
  exp_t q3 [$];
  int   glog [$];
  int   ptr = 0;
  int   n_issued = 0;
  int   wt [N] = '{default: 0};
  int   max_wait = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int model_gnt(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: check grants at the negedge, push expectations, retire the granted request.
  task automatic step();
    int           g;
    logic [N-1:0] one;
    logic [N-1:0] eoh;
    exp_t         e;
    one = 1;
    @(negedge clock);
    g   = rst_n ? model_gnt(pend) : -1;
    eoh = (g >= 0) ? (one << g) : '0;
    check("req_ready l1", ready1, eoh);
    check("req_ready l3", ready3, eoh);
    for (int i = 0; i < N; i++) begin
      if (ready1[i]) glog.push_back(i);
      if (rst_n && pend[i] && !ready1[i]) begin
        wt[i]++;
        if (wt[i] > max_wait) max_wait = wt[i];
      end else begin
        wt[i] = 0;
      end
    end
    if (g >= 0) begin
      e.id  = g;
      e.sum = {1'b0, pa[g]} + {1'b0, pb[g]};
      e.due = cyc + 1 + 2;
      q1.push_back(e);
      e.due = cyc + 3 + 2;
      q3.push_back(e);
      ptr = (g + 1) % N;
      n_issued++;
    end
    @(posedge clock);
    #1;
    if (g >= 0) pend[g] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q1.delete();
    q3.delete();
    ptr = 0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    @(negedge clock);
    check("rst req_ready l1", ready1, 0);
    check("rst req_ready l3", ready3, 0);
    check("rst rsp_valid l1", rsp_valid1, 0);
    check("rst rsp_valid l3", rsp_valid3, 0);
    check("rst busy l1", busy1, 0);
    check("rst busy l3", busy3, 0);
    check("rst add_a", add_a1, 0);
    check("rst add_b", add_b1, 0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic raise(input int i);
    int r;
    r = $urandom_range(0, 7);
    pend[i] = 1'b1;
    pa[i] = (r == 0) ? 32'hFFFF_FFFF : (r == 1) ? 32'h0 : W'($urandom);
    pb[i] = (r == 0) ? 32'hFFFF_FFFF : (r == 2) ? 32'h0 : W'($urandom);
  endtask

  task automatic mon(input string nm, input int lat, input bit have, input exp_t e,
                     input logic [N-1:0] v, input logic [IDW-1:0] id, input logic [W:0] sum,
                     input logic bsy, output bit pop);
    logic [N-1:0] one;
    logic [N-1:0] ev;
    bit           due;
    bit           eb;
    one = 1;
    due = have && (e.due == cyc);
    ev  = due ? (one << e.id) : '0;
    eb  = have && (e.due - lat - 1 <= cyc);
    pop = have && (e.due <= cyc);
    if (due || v != '0) check({nm, " rsp_valid"}, v, ev);
    if (due) begin
      check({nm, " rsp_id"}, id, e.id);
      check({nm, " rsp_sum"}, sum, e.sum);
    end
    if (eb || bsy) check({nm, " busy"}, bsy, eb);
  endtask

  exp_t dflt;
  always @(negedge clock) begin
    bit   p;
    exp_t f;
    if (rst_n) begin
      f = (q1.size() > 0) ? q1[0] : dflt;
      mon("l1", 1, q1.size() > 0, f, rsp_valid1, rsp_id1, rsp_sum1, busy1, p);
      if (p) void'(q1.pop_front());
      f = (q3.size() > 0) ? q3[0] : dflt;
      mon("l3", 3, q3.size() > 0, f, rsp_valid3, rsp_id3, rsp_sum3, busy3, p);
      if (p) void'(q3.pop_front());
    end
  end

  int e8 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int e4 [4] = '{1, 3, 0, 1};

  initial begin
    int guard;
    for (int i = 0; i < N; i++) begin pa[i] = '0; pb[i] = '0; end
    #2;
    for (int i = 0; i < N; i++) raise(i);
    do_reset();

    // All requesters continuously valid: strict rotation from 0.
    glog.delete();
    repeat (8) begin
      step();
      for (int i = 0; i < N; i++) if (!pend[i]) raise(i);
    end
    check("rr count", glog.size(), 8);
    for (int k = 0; k < 8; k++) check("rr order", glog[k], e8[k]);
    repeat (10) step();

    // Single op with carry-out.
    glog.delete();
    pend[2] = 1'b1; pa[2] = 32'hFFFF_FFFF; pb[2] = 32'h1;
    step();
    check("single grant", glog.size() > 0 ? glog[0] : -1, 2);
    repeat (6) step();

    // Pointer wrap and late arrival at the pointer.
    glog.delete();
    raise(1); step();
    raise(1); raise(3); step();
    raise(0); step();
    step();
    check("wrap count", glog.size(), 4);
    for (int k = 0; k < 4; k++) check("wrap order", glog[k], e4[k]);
    repeat (6) step();

    // Reset while two ops are in flight, then a fresh op.
    raise(0); raise(1);
    step(); step(); step();
    do_reset();
    raise(3);
    step();
    repeat (8) step();

    // Random soak.
    n_issued = 0;
    guard = 0;
    while (n_issued < 1000 && guard < 20000) begin
      if ($urandom_range(0, 15) != 0) begin
        for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 2) != 0) raise(i);
      end
      step();
      guard++;
    end
    check("soak issued", n_issued >= 1000, 1);
    repeat (12) step();
    check("l1 queue drained", q1.size(), 0);
    check("l3 queue drained", q3.size(), 0);
    check("max wait", max_wait <= N - 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
